// File: rtl/hyperbus_resp_pkg.sv
// Shared types and decode helpers for the HyperBus memory responder.
package hyperbus_resp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CA,
    ST_LAT,
    ST_REG_WR,
    ST_DATA_RD,
    ST_DATA_WR,
    ST_WAIT_CS
  } state_t;

  typedef struct packed {
    logic        rw;
    logic        as;
    logic        burst;
    logic [28:0] row;
    logic [12:0] rsvd;
    logic [2:0]  col;
  } ca_t;

  localparam logic [31:0] CR0_ADDR = 32'h800;

  function automatic logic [3:0] latency_decode(input logic [3:0] code);
    case (code)
      4'hE:    latency_decode = 4'd3;
      4'hF:    latency_decode = 4'd4;
      4'h0:    latency_decode = 4'd5;
      4'h1:    latency_decode = 4'd6;
      4'h2:    latency_decode = 4'd7;
      default: latency_decode = 4'd6;
    endcase
  endfunction

  function automatic logic [6:0] wrap_len(input logic [1:0] sel);
    case (sel)
      2'b00:   wrap_len = 7'd64;
      2'b01:   wrap_len = 7'd32;
      2'b10:   wrap_len = 7'd8;
      default: wrap_len = 7'd16;
    endcase
  endfunction

endpackage

// File: rtl/hyperbus_resp_mem.sv
// Single-port 16-bit word array with per-byte write enables and asynchronous read.
module hyperbus_resp_mem #(
  parameter int WORDS = 1024,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk_i,
  input  logic [1:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [15:0]   wdata_i,
  output logic [15:0]   rdata_o
);

  logic [15:0] mem_q [WORDS];

  always_ff @(posedge clk_i) begin
    if (be_i[1]) mem_q[addr_i][15:8] <= wdata_i[15:8];
    if (be_i[0]) mem_q[addr_i][7:0]  <= wdata_i[7:0];
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/hyperbus_mem_responder.sv
// HyperBus device-side responder: CA decode, latency/RWDS signalling, memory and CR0 access.
// Optional refresh-window latency forcing is enabled by defining HYPERBUS_RESP_REFRESH_EN.
module hyperbus_mem_responder
  import hyperbus_resp_pkg::*;
#(
  parameter int          MEM_WORDS      = 1024,
  parameter logic [15:0] CR0_RESET      = 16'h8F1F,
  parameter int          REFRESH_PERIOD = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cs_ni,
  input  logic        ck_en_i,
  input  logic [15:0] dq_i,
  input  logic [1:0]  rwds_i,
  output logic [15:0] dq_o,
  output logic        dq_oe_o,
  output logic [1:0]  rwds_o,
  output logic        rwds_oe_o
);

  localparam int AW = $clog2(MEM_WORDS);

  state_t      state_q, state_d;
  logic [1:0]  ca_cnt_q, ca_cnt_d;
  logic [31:0] ca_sh_q, ca_sh_d;
  logic        rw_q, rw_d, as_q, as_d, linear_q, linear_d, dbl_q, dbl_d;
  logic [4:0]  lat_q, lat_d;
  logic [31:0] addr_q, addr_d, addr_nxt, rd_addr, wrap_mask;
  logic [15:0] cr0_q, cr0_d, dq_q, dq_d, mem_rdata, rd_word;
  logic        dq_oe_q, dq_oe_d, rwds_oe_q, rwds_oe_d;
  logic [1:0]  rwds_q, rwds_d, mem_be;
  logic [3:0]  lat_base;
  logic        refresh_win;
  logic        unused_rsvd;
  ca_t         ca_full;

`ifdef HYPERBUS_RESP_REFRESH_EN
  localparam int RCW = $clog2(REFRESH_PERIOD);
  logic [RCW-1:0] ref_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                 ref_cnt_q <= '0;
    else if (ref_cnt_q == RCW'(REFRESH_PERIOD-1)) ref_cnt_q <= '0;
    else                                         ref_cnt_q <= ref_cnt_q + 1'b1;
  end

  assign refresh_win = (ref_cnt_q < RCW'(8));
`else
  localparam int unused_refresh_period = REFRESH_PERIOD;
  assign refresh_win = 1'b0;
`endif

  // The third CA word is still on dq_i when the decode decision is taken.
  assign ca_full     = ca_t'({ca_sh_q, dq_i});
  assign unused_rsvd = ^ca_full.rsvd;
  assign lat_base    = latency_decode(cr0_q[7:4]);
  assign wrap_mask   = 32'(wrap_len(cr0_q[1:0])) - 32'd1;
  assign addr_nxt    = linear_q ? addr_q + 32'd1
                                : (addr_q & ~wrap_mask) | ((addr_q + 32'd1) & wrap_mask);
  // Reads prefetch the following word so dq_o stays one word per ck_en cycle.
  assign rd_addr     = (state_q == ST_DATA_RD) ? addr_nxt : addr_q;
  assign rd_word     = !as_q ? mem_rdata : ((rd_addr == CR0_ADDR) ? cr0_q : 16'h0000);

  hyperbus_resp_mem #(.WORDS(MEM_WORDS), .AW(AW)) u_mem (
    .clk_i   (clk_i),
    .be_i    (mem_be),
    .addr_i  (rd_addr[AW-1:0]),
    .wdata_i (dq_i),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    state_d   = state_q;
    ca_cnt_d  = ca_cnt_q;
    ca_sh_d   = ca_sh_q;
    rw_d      = rw_q;
    as_d      = as_q;
    linear_d  = linear_q;
    dbl_d     = dbl_q;
    lat_d     = lat_q;
    addr_d    = addr_q;
    cr0_d     = cr0_q;
    dq_d      = dq_q;
    dq_oe_d   = 1'b0;
    rwds_oe_d = 1'b0;
    rwds_d    = 2'b00;
    mem_be    = 2'b00;
    if (cs_ni) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d   = ST_CA;
          ca_cnt_d  = 2'd0;
          dbl_d     = cr0_q[3] | refresh_win;
          rwds_oe_d = 1'b1;
          rwds_d    = {2{cr0_q[3] | refresh_win}};
        end
        ST_CA: begin
          rwds_oe_d = 1'b1;
          rwds_d    = {2{dbl_q}};
          if (ck_en_i) begin
            ca_sh_d  = ca_full[31:0];
            ca_cnt_d = ca_cnt_q + 2'd1;
            if (ca_cnt_q == 2'd2) begin
              rw_d      = ca_full.rw;
              as_d      = ca_full.as;
              linear_d  = ca_full.burst;
              addr_d    = {ca_full.row, ca_full.col};
              lat_d     = (dbl_q ? {lat_base, 1'b0} : {1'b0, lat_base}) - 5'd1;
              rwds_oe_d = 1'b0;
              rwds_d    = 2'b00;
              state_d   = (!ca_full.rw && ca_full.as) ? ST_REG_WR : ST_LAT;
            end
          end
        end
        ST_LAT: begin
          if (ck_en_i) begin
            if (lat_q == 5'd1) begin
              if (rw_q) begin
                state_d   = ST_DATA_RD;
                dq_d      = rd_word;
                dq_oe_d   = 1'b1;
                rwds_oe_d = 1'b1;
                rwds_d    = 2'b10;
              end else begin
                state_d = ST_DATA_WR;
              end
            end else begin
              lat_d = lat_q - 5'd1;
            end
          end
        end
        ST_REG_WR: begin
          if (ck_en_i) begin
            if (addr_q == CR0_ADDR) cr0_d = dq_i;
            state_d = ST_WAIT_CS;
          end
        end
        ST_DATA_RD: begin
          dq_oe_d   = 1'b1;
          rwds_oe_d = 1'b1;
          rwds_d    = 2'b10;
          if (ck_en_i) begin
            dq_d   = rd_word;
            addr_d = addr_nxt;
          end
        end
        ST_DATA_WR: begin
          if (ck_en_i) begin
            mem_be = as_q ? 2'b00 : ~rwds_i;
            addr_d = addr_nxt;
          end
        end
        ST_WAIT_CS: state_d = ST_WAIT_CS;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      ca_cnt_q  <= 2'd0;
      ca_sh_q   <= '0;
      rw_q      <= 1'b0;
      as_q      <= 1'b0;
      linear_q  <= 1'b0;
      dbl_q     <= 1'b0;
      lat_q     <= '0;
      addr_q    <= '0;
      cr0_q     <= CR0_RESET;
      dq_q      <= '0;
      dq_oe_q   <= 1'b0;
      rwds_oe_q <= 1'b0;
      rwds_q    <= 2'b00;
    end else begin
      state_q   <= state_d;
      ca_cnt_q  <= ca_cnt_d;
      ca_sh_q   <= ca_sh_d;
      rw_q      <= rw_d;
      as_q      <= as_d;
      linear_q  <= linear_d;
      dbl_q     <= dbl_d;
      lat_q     <= lat_d;
      addr_q    <= addr_d;
      cr0_q     <= cr0_d;
      dq_q      <= dq_d;
      dq_oe_q   <= dq_oe_d;
      rwds_oe_q <= rwds_oe_d;
      rwds_q    <= rwds_d;
    end
  end

  assign dq_o      = dq_q;
  assign dq_oe_o   = dq_oe_q;
  assign rwds_o    = rwds_q;
  assign rwds_oe_o = rwds_oe_q;

endmodule
